// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle arithmetic/logic/MOV/LUI, iterative one-bit-per-cycle shifts,
// valid/ready handshake on both sides and a persistent {C,L,F,Z,N} status register.
module alu_exec_unit #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       alu_opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             write_en,
  output logic [4:0]       flags,
  output logic             err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int unsigned FLG_C = 4;
  localparam int unsigned FLG_L = 3;
  localparam int unsigned FLG_F = 2;
  localparam int unsigned FLG_Z = 1;
  localparam int unsigned FLG_N = 0;

  localparam logic [7:0] OP_AND  = 8'h01;
  localparam logic [7:0] OP_OR   = 8'h02;
  localparam logic [7:0] OP_XOR  = 8'h03;
  localparam logic [7:0] OP_ADD  = 8'h05;
  localparam logic [7:0] OP_ADDU = 8'h06;
  localparam logic [7:0] OP_ADDC = 8'h07;
  localparam logic [7:0] OP_SUB  = 8'h09;
  localparam logic [7:0] OP_SUBC = 8'h0A;
  localparam logic [7:0] OP_CMP  = 8'h0B;
  localparam logic [7:0] OP_MOV  = 8'h0D;
  localparam logic [7:0] OP_LSH  = 8'h84;
  localparam logic [7:0] OP_ASHU = 8'h86;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_result;
  logic               r_write_en;
  logic               r_err;
  logic [4:0]         r_flags;
  logic [WIDTH-1:0]   r_work;
  logic [SHAMT_W-1:0] r_count;
  logic               r_shift_left;
  logic               r_shift_arith;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic               w_cin;
  logic               w_bin;
  logic               w_add_ovf;
  logic               w_sub_ovf;
  logic [WIDTH-1:0]   w_exec_result;
  logic [4:0]         w_exec_flags;
  logic               w_exec_we;
  logic               w_exec_err;
  logic               w_is_shift;
  logic               w_shift_arith;
  logic [SHAMT_W-1:0] w_shamt;
  logic [SHAMT_W-1:0] w_shamt_mag;
  logic               w_shamt_nz;
  logic [WIDTH-1:0]   w_work_step;

  // Both sums are one bit wider so the top bit is carry (add) or borrow (subtract).
  assign w_cin     = (alu_opcode == OP_ADDC) & r_flags[FLG_C];
  assign w_bin     = (alu_opcode == OP_SUBC) & r_flags[FLG_C];
  assign w_sum     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, w_cin};
  assign w_diff    = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, w_bin};
  assign w_add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
  assign w_sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);

  // Signed shift amount: sign selects direction, magnitude seeds the iteration counter.
  assign w_shamt     = b[SHAMT_W-1:0];
  assign w_shamt_nz  = |w_shamt;
  assign w_shamt_mag = w_shamt[SHAMT_W-1] ? SHAMT_W'(~w_shamt + 1'b1) : w_shamt;
  assign w_work_step = r_shift_left ? {r_work[WIDTH-2:0], 1'b0}
                                    : {r_shift_arith & r_work[WIDTH-1], r_work[WIDTH-1:1]};

  // Single-cycle execution of the operation presented at the input.
  always_comb begin
    w_exec_result = '0;
    w_exec_flags  = r_flags;
    w_exec_we     = 1'b1;
    w_exec_err    = 1'b0;
    w_is_shift    = 1'b0;
    w_shift_arith = 1'b0;
    case (alu_opcode)
      OP_AND:  w_exec_result = a & b;
      OP_OR:   w_exec_result = a | b;
      OP_XOR:  w_exec_result = a ^ b;
      OP_ADDU: w_exec_result = w_sum[WIDTH-1:0];
      OP_ADD, OP_ADDC: begin
        w_exec_result       = w_sum[WIDTH-1:0];
        w_exec_flags[FLG_C] = w_sum[WIDTH];
        w_exec_flags[FLG_F] = w_add_ovf;
        w_exec_flags[FLG_Z] = ~|w_sum[WIDTH-1:0];
        w_exec_flags[FLG_N] = w_sum[WIDTH-1];
      end
      OP_SUB, OP_SUBC: begin
        w_exec_result       = w_diff[WIDTH-1:0];
        w_exec_flags[FLG_C] = w_diff[WIDTH];
        w_exec_flags[FLG_F] = w_sub_ovf;
        w_exec_flags[FLG_Z] = ~|w_diff[WIDTH-1:0];
        w_exec_flags[FLG_N] = w_diff[WIDTH-1];
      end
      OP_CMP: begin
        w_exec_result       = w_diff[WIDTH-1:0];
        w_exec_we           = 1'b0;
        w_exec_flags[FLG_Z] = (a == b);
        w_exec_flags[FLG_L] = (a < b);
        w_exec_flags[FLG_N] = ($signed(a) < $signed(b));
      end
      OP_MOV:  w_exec_result = b;
      OP_LSH, OP_ASHU: begin
        w_exec_result = a;
        w_is_shift    = 1'b1;
        w_shift_arith = (alu_opcode == OP_ASHU);
      end
      default: begin
        if (alu_opcode[7:4] == 4'hF) begin
          w_exec_result = {b[7:0], {(WIDTH-8){1'b0}}};
        end else begin
          w_exec_we  = 1'b0;
          w_exec_err = 1'b1;
        end
      end
    endcase
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (in_valid) w_state_nxt = (w_is_shift && w_shamt_nz) ? ST_SHIFT : ST_DONE;
      ST_SHIFT: if (r_count == SHAMT_W'(1)) w_state_nxt = ST_DONE;
      ST_DONE:  if (out_ready) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_in_ready    <= 1'b1;
      r_out_valid   <= 1'b0;
      r_result      <= '0;
      r_write_en    <= 1'b0;
      r_err         <= 1'b0;
      r_flags       <= '0;
      r_work        <= '0;
      r_count       <= '0;
      r_shift_left  <= 1'b0;
      r_shift_arith <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == ST_IDLE);
      r_out_valid <= (w_state_nxt == ST_DONE);
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_result      <= w_exec_result;
            r_write_en    <= w_exec_we;
            r_err         <= w_exec_err;
            r_flags       <= w_exec_flags;
            r_work        <= a;
            r_count       <= w_shamt_mag;
            r_shift_left  <= ~w_shamt[SHAMT_W-1];
            r_shift_arith <= w_shift_arith;
          end
        end
        ST_SHIFT: begin
          r_work  <= w_work_step;
          r_count <= r_count - SHAMT_W'(1);
          if (r_count == SHAMT_W'(1)) r_result <= w_work_step;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign write_en  = r_write_en;
  assign err       = r_err;
  assign flags     = r_flags;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed corner cases plus randomized operations
// compared against an arithmetic reference model of the opcode rules.
module tb_alu_exec_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  alu_opcode;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        write_en;
  logic [4:0]  flags;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;
  logic [4:0] m_flags;

  alu_exec_unit #(.WIDTH(16), .SHAMT_W(5)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_opcode(alu_opcode), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .write_en(write_en), .flags(flags), .err(err)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: flags are {C,L,F,Z,N}; arithmetic done on plain ints.
  task automatic ref_model(input logic [7:0] op, input logic [15:0] av, input logic [15:0] bv,
                           input logic [4:0] fin, output logic [15:0] res, output logic we,
                           output logic er, output logic [4:0] fo, output int lat, output bit chk_res);
    int ua, ub, sa, sb, cin, s, ss, n;
    logic signed [4:0]  n5;
    logic signed [15:0] sv;
    ua = int'(av);
    ub = int'(bv);
    sa = int'($signed(av));
    sb = int'($signed(bv));
    fo = fin; we = 1'b1; er = 1'b0; lat = 1; chk_res = 1'b1; res = '0;
    case (op)
      8'h01: res = av & bv;
      8'h02: res = av | bv;
      8'h03: res = av ^ bv;
      8'h06: res = 16'(ua + ub);
      8'h05, 8'h07: begin
        cin   = (op == 8'h07) ? int'(fin[4]) : 0;
        s     = ua + ub + cin;
        ss    = sa + sb + cin;
        res   = 16'(s);
        fo[4] = (s > 65535);
        fo[2] = (ss > 32767) || (ss < -32768);
        fo[1] = (res == 16'h0000);
        fo[0] = res[15];
      end
      8'h09, 8'h0A: begin
        cin   = (op == 8'h0A) ? int'(fin[4]) : 0;
        ss    = sa - sb - cin;
        res   = 16'(ua - ub - cin);
        fo[4] = (ua < ub + cin);
        fo[2] = (ss > 32767) || (ss < -32768);
        fo[1] = (res == 16'h0000);
        fo[0] = res[15];
      end
      8'h0B: begin
        we = 1'b0; chk_res = 1'b0;
        fo[1] = (av == bv);
        fo[3] = (ua < ub);
        fo[0] = (sa < sb);
      end
      8'h0D: res = bv;
      8'h84, 8'h86: begin
        n5  = bv[4:0];
        n   = int'(n5);
        lat = (n == 0) ? 1 : ((n < 0) ? -n : n) + 1;
        if (n >= 0) res = av << n;
        else if (op == 8'h84) res = av >> (-n);
        else begin
          sv  = av;
          res = sv >>> (-n);
        end
      end
      default: begin
        if (op >= 8'hF0) res = {bv[7:0], 8'h00};
        else begin
          we = 1'b0; er = 1'b1;
        end
      end
    endcase
  endtask

  // Issue one op, measure latency, hold out_ready low for 'hold' cycles, then retire it.
  task automatic run_op(input logic [7:0] op, input logic [15:0] av, input logic [15:0] bv, input int hold);
    logic [15:0] e_res;
    logic        e_we, e_err;
    logic [4:0]  e_fl;
    int          e_lat, cyc;
    bit          chk_res;
    ref_model(op, av, bv, m_flags, e_res, e_we, e_err, e_fl, e_lat, chk_res);
    m_flags = e_fl;
    @(negedge clock);
    check_eq("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; alu_opcode = op; a = av; b = bv; out_ready = 1'b0;
    @(negedge clock);
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      check_eq("in_ready_busy", in_ready, 0);
      @(negedge clock);
      cyc++;
    end
    check_eq("out_valid", out_valid, 1);
    check_eq("latency", cyc, e_lat);
    if (chk_res) check_eq("result", result, e_res);
    check_eq("write_en", write_en, e_we);
    check_eq("err", err, e_err);
    check_eq("flags", flags, e_fl);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; alu_opcode = 8'h0D; a = ~av; b = ~bv;
      @(negedge clock);
      check_eq("hold_out_valid", out_valid, 1);
      check_eq("hold_in_ready", in_ready, 0);
      if (chk_res) check_eq("hold_result", result, e_res);
      check_eq("hold_flags", flags, e_fl);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    check_eq("retire_out_valid", out_valid, 0);
    check_eq("retire_in_ready", in_ready, 1);
  endtask

  logic [7:0] legal_ops [12] = '{8'h01, 8'h02, 8'h03, 8'h05, 8'h06, 8'h07,
                                 8'h09, 8'h0A, 8'h0B, 8'h0D, 8'h84, 8'h86};

  initial begin
    int         sel;
    logic [7:0] op;
    reset = 1'b1; in_valid = 1'b0; alu_opcode = '0; a = '0; b = '0; out_ready = 1'b0;
    m_flags = '0;
    repeat (2) @(negedge clock);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_result", result, 0);
    check_eq("rst_flags", flags, 0);
    check_eq("rst_err_we", {err, write_en}, 0);
    reset = 1'b0;

    run_op(8'h05, 16'h7FFF, 16'h0001, 0);   // 8000, F=1 N=1
    run_op(8'h09, 16'h0003, 16'h0005, 0);   // FFFE, C=1 N=1
    run_op(8'h0B, 16'h0005, 16'h0005, 0);   // Z=1 L=0, no write
    run_op(8'h84, 16'h00F0, 16'h001C, 0);   // right by 4 -> 000F
    run_op(8'h86, 16'h8000, 16'h0010, 0);   // right by 16 -> FFFF
    run_op(8'h84, 16'h8001, 16'h0010, 0);   // right by 16 -> 0000
    run_op(8'h84, 16'hFFFF, 16'h000F, 0);   // left by 15 -> 8000
    run_op(8'h86, 16'h1234, 16'h0000, 0);   // amount 0
    run_op(8'h06, 16'h1234, 16'h1111, 10);  // backpressure
    run_op(8'h4C, 16'h1234, 16'h5678, 2);   // illegal
    run_op(8'hF3, 16'h0000, 16'h00AB, 0);   // LUI -> AB00
    run_op(8'h05, 16'hFFFF, 16'h0001, 0);   // carry out, Z
    run_op(8'h07, 16'h0001, 16'h0001, 0);   // ADDC with C=1
    run_op(8'h09, 16'h0000, 16'h0001, 0);   // borrow
    run_op(8'h0A, 16'h8000, 16'h0000, 0);   // SUBC with C=1, overflow

    // Reset during the third cycle of a 10-bit shift.
    run_op(8'h05, 16'h7FFF, 16'h7FFF, 0);
    @(negedge clock);
    in_valid = 1'b1; alu_opcode = 8'h84; a = 16'h0001; b = 16'h000A;
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    m_flags = '0;
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_in_ready", in_ready, 1);
    check_eq("midrst_flags", flags, 0);
    sel = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      if (out_valid) sel++;
    end
    check_eq("midrst_no_stale", sel, 0);

    for (int i = 0; i < 300; i++) begin
      sel = int'($urandom_range(0, 13));
      if (sel < 12) op = legal_ops[sel];
      else if (sel == 12) op = 8'hF0 | 8'($urandom_range(0, 15));
      else op = 8'($urandom);
      run_op(op, 16'($urandom), 16'($urandom), int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
